uart_byte_tx: RTL and testbench

- Serial 8N1 UART transmitter driving the board UART_TXD pin; this is the transmit end of the RS-232 link whose receive pin is UART_RXD.
- Accepts one byte per valid/ready handshake and shifts it out LSB first at a fixed baud rate.
- Typical use: reports the key-driven counter value and other status bytes to a PC terminal.
- Sits between the board top (replacing the constant-high UART_TXD tie) and any byte-producing logic.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_bit_timer.sv | 43 ++++
 rtl/uart_byte_tx.sv | 144 ++++++++++++++
 tb/tb_uart_byte_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the byte transmitter and the future byte receiver:
// state encoding, data width and the bit-period calculation.
`timescale 1ns/1ps
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Clock cycles per serial bit, truncated (434 for 50 MHz / 115200).
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Width of a counter holding 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. Pulses bit_done_o on the last cycle of every
// CLKS_PER_BIT-cycle period while enabled. restart_i loads load_i, so the
// transmitter starts a full period on frame start and the receiver can
// preload half a bit to land its samples mid-bit.
`timescale 1ns/1ps
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434,
   parameter int W            = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         restart_i,
   input  logic [W-1:0] load_i,
   output logic         bit_done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: restart wins, then reload at terminal count, else decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (restart_i)
         cnt_d = load_i;
      else if (en_i) begin
         if (cnt_q == '0)
            cnt_d = W'(CLKS_PER_BIT - 1);
         else
            cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign bit_done_o = en_i & ~restart_i & (cnt_q == '0);

endmodule

// File: rtl/uart_byte_tx.sv
// Serial UART byte transmitter (8N1 / 8N2), LSB first, valid/ready input.
// Build option: define UART_TX_PARITY_EN to insert a parity bit between the
// last data bit and the stop bit(s); PARITY_ODD selects its sense.
//
// state  | meaning
// IDLE   | line at mark, tx_ready high, waiting for tx_valid
// START  | start bit (0) for one bit period
// DATA   | D0..D7, bit index in idx_q
// PARITY | parity bit (only with UART_TX_PARITY_EN)
// STOP   | mark for STOP_BITS bit periods, stop count in idx_q
`timescale 1ns/1ps
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic       FPGA_CLK,
   input  logic       RESET_BUT,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       UART_TXD
);

   localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW  = cnt_width(CPB);

   if (!((STOP_BITS == 1 || STOP_BITS == 2) && (PARITY_ODD == 0 || PARITY_ODD == 1))) begin : g_cfg_check
      $error("uart_byte_tx: STOP_BITS must be 1 or 2 and PARITY_ODD 0 or 1");
   end

   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [2:0]           idx_q, idx_d;
   logic                 txd_q, txd_d;
   logic                 restart;
   logic                 bit_done;

   uart_bit_timer #(
      .CLKS_PER_BIT (CPB),
      .W            (CW)
   ) u_timer (
      .clk_i      (FPGA_CLK),
      .rst_i      (RESET_BUT),
      .en_i       (state_q != IDLE),
      .restart_i  (restart),
      .load_i     (CW'(CPB - 1)),
      .bit_done_o (bit_done)
   );

   // Frame sequencing; the next line level is computed here so that
   // UART_TXD comes straight from a flop.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      idx_d   = idx_q;
      txd_d   = txd_q;
      restart = 1'b0;
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (tx_valid) begin
               data_d  = tx_data;
               idx_d   = 3'd0;
               txd_d   = 1'b0;
               restart = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               idx_d   = 3'd0;
               txd_d   = data_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               if (idx_q == 3'(DATA_BITS - 1)) begin
                  idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                  txd_d   = (^data_q) ^ (PARITY_ODD != 0);
                  state_d = PARITY;
`else
                  txd_d   = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
                  txd_d = data_q[idx_q + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               idx_d   = 3'd0;
               txd_d   = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            txd_d = 1'b1;
            if (bit_done) begin
               if (idx_q == 3'(STOP_BITS - 1)) begin
                  idx_d   = 3'd0;
                  state_d = IDLE;
               end else
                  idx_d = idx_q + 3'd1;
            end
         end
         default: begin
            idx_d   = 3'd0;
            txd_d   = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // State, latched byte, bit index and line flop; reset drops any frame.
   always_ff @(posedge FPGA_CLK or posedge RESET_BUT) begin
      if (RESET_BUT) begin
         state_q <= IDLE;
         data_q  <= '0;
         idx_q   <= 3'd0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
      end
   end

   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = ~tx_ready;
   assign UART_TXD = txd_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at default parameters (434 clocks per bit).
// With UART_TX_PARITY_EN a second instance with PARITY_ODD=1 runs in lockstep.
`timescale 1ns/1ps
module tb_uart_byte_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, txd;
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   uart_byte_tx dut (
      .FPGA_CLK  (clk),
      .RESET_BUT (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_busy   (tx_busy),
      .UART_TXD  (txd)
   );

`ifdef UART_TX_PARITY_EN
   logic tx_ready2, tx_busy2, txd2;
   uart_byte_tx #(.PARITY_ODD(1)) dut_odd (
      .FPGA_CLK  (clk),
      .RESET_BUT (rst),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready2),
      .tx_busy   (tx_busy2),
      .UART_TXD  (txd2)
   );
`endif

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 6000) begin
         cyc(1);
         n++;
      end
      chk({tag, "_ready_wait"}, 16'(tx_ready), 16'd1);
   endtask

   // Present a byte; returns just after the accept edge k.
   task automatic send(input string tag, input logic [7:0] d, input bit hold);
      wait_ready(tag);
      tx_data  = d;
      tx_valid = 1'b1;
      cyc(1);
      if (!hold) tx_valid = 1'b0;
   endtask

   // Decode one frame starting just after accept edge k, sampling mid-bit,
   // and check tx_ready rises exactly at k+4340 (k+4774 with parity).
   task automatic frame_rx(input string tag, input logic [7:0] exp);
      logic [7:0] d;
      chk({tag, "_start_first"}, 16'(txd), 16'd0);
      chk({tag, "_busy"}, 16'(tx_busy), 16'd1);
      cyc(217);
      chk({tag, "_start_mid"}, 16'(txd), 16'd0);
      cyc(216);
      chk({tag, "_start_last"}, 16'(txd), 16'd0);
      cyc(218);
      d[0] = txd;
      for (int i = 1; i < 8; i++) begin
         cyc(434);
         d[i] = txd;
      end
      chk({tag, "_data"}, 16'(d), 16'(exp));
`ifdef UART_TX_PARITY_EN
      cyc(434);
      chk({tag, "_parity_even"}, 16'(txd), 16'(^exp));
      chk({tag, "_parity_odd"}, 16'(txd2), 16'(~^exp));
`endif
      cyc(434);
      chk({tag, "_stop"}, 16'(txd), 16'd1);
      cyc(216);
      chk({tag, "_ready_early"}, 16'(tx_ready), 16'd0);
      cyc(1);
      chk({tag, "_ready_at_end"}, 16'(tx_ready), 16'd1);
      chk({tag, "_busy_at_end"}, 16'(tx_busy), 16'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol;

      // Reset and idle
      rst = 1'b1;
      cyc(5);
      chk("rst_txd", 16'(txd), 16'd1);
      chk("rst_ready", 16'(tx_ready), 16'd1);
      chk("rst_busy", 16'(tx_busy), 16'd0);
      rst = 1'b0;
      viol = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc(1);
         if (txd !== 1'b1 || tx_ready !== 1'b1) viol++;
      end
      chk("idle_violations", 16'(viol), 16'd0);

      // Single byte 0xA5
      send("a5", 8'hA5, 1'b0);
      frame_rx("a5", 8'hA5);

      // Back-to-back 0x00 then 0xFF, tx_valid held high
      send("b2b", 8'h00, 1'b1);
      tx_data = 8'hFF;
      frame_rx("b2b_00", 8'h00);
      chk("b2b_mark", 16'(txd), 16'd1);
      cyc(1);
      tx_valid = 1'b0;
      frame_rx("b2b_ff", 8'hFF);

      // tx_data changes while busy are ignored; valid low so 0x3C never goes out
      send("chg", 8'h81, 1'b0);
      tx_data = 8'h3C;
      frame_rx("chg_81", 8'h81);
      viol = 0;
      for (int i = 0; i < 600; i++) begin
         cyc(1);
         if (txd !== 1'b1 || tx_busy !== 1'b0) viol++;
      end
      chk("chg_no_resend", 16'(viol), 16'd0);

      // Asynchronous reset during data bit 4 of 0x0F (bit 4 is 0)
      send("rst_mid", 8'h0F, 1'b0);
      cyc(434 * 5 + 200);
      chk("rst_mid_pre_txd", 16'(txd), 16'd0);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_txd", 16'(txd), 16'd1);
      chk("rst_mid_ready", 16'(tx_ready), 16'd1);
      chk("rst_mid_busy", 16'(tx_busy), 16'd0);
      cyc(3);
      rst = 1'b0;
      cyc(2);
      chk("post_rst_idle", 16'(txd), 16'd1);
      send("post_rst", 8'h55, 1'b0);
      frame_rx("post_rst_55", 8'h55);

      // 0x07: odd popcount, parity bit 1 (even) / 0 (odd) when enabled
      send("p07", 8'h07, 1'b0);
      frame_rx("p07", 8'h07);
`ifdef UART_TX_PARITY_EN
      chk("p07_odd_ready", 16'(tx_ready2), 16'd1);
      chk("p07_odd_busy", 16'(tx_busy2), 16'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
